// File: rtl/zx_bus_responder.sv
// zx_bus_responder: answers Z80 reads of screen memory (BASE_ADDR..TOP_ADDR) on the data bus.
// Optional ULA input port (keyboard/EAR) enabled by defining ULA_PORT_EN.
module zx_bus_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] BASE_ADDR   = 16'h4000,
  parameter logic [15:0] TOP_ADDR    = 16'h5AFF,
  parameter int          TIMEOUT     = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] a_i,
  input  logic        rd_i,
  input  logic        mrq_i,
  input  logic        iorq_i,
  input  logic        m1_i,
  output logic [12:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic [7:0]  mem_data_i,
  output logic [7:0]  d_out_o,
  output logic        d_oe_o,
  input  logic [4:0]  keys_i,
  input  logic        ear_i,
  output logic        err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, DRIVE, RELEASE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]  ctl_q;
  logic [SYNC_STAGES-1:0][15:0] adr_q;
  logic [SYNC_STAGES-1:0]       vld_q;
  logic        rd_s, mrq_s, iorq_s, m1_s, vld;
  logic [15:0] a_s;
  logic [12:0] off, mem_addr_q, mem_addr_d;
  logic [7:0]  d_out_q, d_out_d, io_dout;
  logic        mem_act, mem_prev_q, mem_start, io_act, io_prev_q, io_start;
  logic        io_q, io_d, rel, tmo, err_q, err_d, mem_rd_q, d_oe_q;
  logic [CW-1:0] cnt_q, cnt_d;
  assign {rd_s, mrq_s, iorq_s, m1_s} = ctl_q[SYNC_STAGES-1];
  assign a_s = adr_q[SYNC_STAGES-1];
  assign vld = vld_q[SYNC_STAGES-1];
  assign off = 13'(a_s - BASE_ADDR);
  assign mem_act = ~mrq_s & ~rd_s;
  assign mem_start = vld & mem_act & ~mem_prev_q & (a_s >= BASE_ADDR) & (a_s <= TOP_ADDR);
`ifdef ULA_PORT_EN
  assign io_act = ~iorq_s & ~rd_s & m1_s & ~a_s[0];
  assign io_start = vld & io_act & ~io_prev_q;
  assign io_dout = {1'b1, ear_i, 1'b1, keys_i};
`else
  logic unused_ula;
  assign unused_ula = ^{keys_i, ear_i, iorq_s, m1_s};
  assign io_act = 1'b0;
  assign io_start = 1'b0;
  assign io_dout = 8'h00;
`endif
  // release follows RD or whichever request strobe opened the access
  assign rel = rd_s | (io_q ? iorq_s : mrq_s);
  assign tmo = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    io_d = io_q;
    mem_addr_d = mem_addr_q;
    d_out_d = d_out_q;
    err_d = err_q;
    case (state_q)
      IDLE:
        if (mem_start) begin
          state_d = FETCH;
          io_d = 1'b0;
          mem_addr_d = off;
        end else if (io_start) begin
          state_d = DRIVE;
          io_d = 1'b1;
          d_out_d = io_dout;
        end
      FETCH: state_d = rel ? RELEASE : LATCH;
      LATCH: begin
        state_d = rel ? RELEASE : DRIVE;
        d_out_d = mem_data_i;
      end
      DRIVE: begin
        state_d = (rel | tmo) ? RELEASE : DRIVE;
        err_d = err_q | (~rel & tmo);
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_q == DRIVE && state_d == DRIVE) ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctl_q <= '1;
      adr_q <= '0;
      vld_q <= '0;
      mem_prev_q <= 1'b1;
      io_prev_q <= 1'b1;
      state_q <= IDLE;
      io_q <= 1'b0;
      cnt_q <= '0;
      mem_rd_q <= 1'b0;
      mem_addr_q <= '0;
      d_out_q <= 8'h00;
      d_oe_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ctl_q <= {ctl_q[SYNC_STAGES-2:0], {rd_i, mrq_i, iorq_i, m1_i}};
      adr_q <= {adr_q[SYNC_STAGES-2:0], a_i};
      vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      // edge history only tracks real bus levels, so a strobe held low through reset never counts as a start
      if (vld) begin
        mem_prev_q <= mem_act;
        io_prev_q <= io_act;
      end
      state_q <= state_d;
      io_q <= io_d;
      cnt_q <= cnt_d;
      mem_rd_q <= state_d == FETCH;
      mem_addr_q <= mem_addr_d;
      d_out_q <= d_out_d;
      d_oe_q <= state_d == DRIVE;
      err_q <= err_d;
    end
  end
  assign mem_addr_o = mem_addr_q;
  assign mem_rd_o = mem_rd_q;
  assign d_out_o = d_out_q;
  assign d_oe_o = d_oe_q;
  assign err_o = err_q;
endmodule

// File: doc/zx_bus_responder.md
ZX_BUS_RESPONDER -- requirements
Module: zx_bus_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for Z80 control strobes, legal range 2-4.
REQ-002 Parameter BASE_ADDR, default 16'h4000: lowest Z80 address served.
REQ-003 Parameter TOP_ADDR, default 16'h5AFF: highest Z80 address served, inclusive.
REQ-004 Parameter TIMEOUT, default 64: maximum CLK cycles the data bus is driven per access.
REQ-005 CLK  input  1  system clock; the block uses one clock only.
REQ-006 RST  input  1  reset, asynchronous, active-low.
REQ-007 A  input  16  Z80 address bus.
REQ-008 RD  input  1  Z80 read strobe, active-low.
REQ-009 MRQ  input  1  Z80 memory request, active-low.
REQ-010 IORQ  input  1  Z80 I/O request, active-low.
REQ-011 M1  input  1  Z80 machine cycle one, active-low.
REQ-012 MEM_ADDR  output  13  screen-memory read address, offset from BASE_ADDR.
REQ-013 MEM_RD  output  1  screen-memory read strobe, one cycle wide.
REQ-014 MEM_DATA  input  8  screen-memory read data, valid the cycle after MEM_RD.
REQ-015 D_OUT  output  8  data presented to the Z80 bus.
REQ-016 D_OE  output  1  drive enable for the external D bus buffer, active-high.
REQ-017 KEYS  input  5  keyboard half-row bits, active-low; used only under ULA_PORT_EN.
REQ-018 EAR  input  1  tape/EAR input bit; used only under ULA_PORT_EN.
REQ-019 ERR  output  1  sticky flag: a drive timeout has occurred.

Function
REQ-020 RD, MRQ, IORQ and M1 SHALL each pass through a SYNC_STAGES-flop synchronizer; A SHALL be delayed by the same depth so that it stays aligned with them.
REQ-021 A memory read start SHALL be the first cycle in which the synchronized MRQ and RD are both low after either one was high.
REQ-022 The FSM states SHALL be IDLE, FETCH, LATCH, DRIVE and RELEASE.
REQ-023 IDLE->FETCH SHALL occur on a memory read start with BASE_ADDR <= A <= TOP_ADDR; an out-of-range read start SHALL leave the FSM in IDLE, with D_OE held low.
REQ-024 In FETCH, MEM_RD SHALL be 1 for exactly one cycle, with MEM_ADDR = A - BASE_ADDR truncated to 13 bits; the next state SHALL be LATCH.
REQ-025 In LATCH, D_OUT SHALL capture MEM_DATA; the next state SHALL be DRIVE.
REQ-026 In DRIVE, D_OE SHALL be 1 and D_OUT SHALL be held stable.
REQ-027 In DRIVE, the FSM SHALL go to RELEASE on the first cycle in which the synchronized RD or the strobe that started the access is high.
REQ-028 Latency SHALL be 3 CLK cycles from the synchronized read start to D_OE high.
REQ-029 In RELEASE, D_OE SHALL be 0; the FSM SHALL return to IDLE after one cycle.
REQ-030 A cycle counter SHALL run in DRIVE. When it reaches TIMEOUT, the FSM SHALL go to RELEASE and set ERR; ERR SHALL stay set until reset.
REQ-031 Opcode fetches (M1 low) in range SHALL be served identically to data reads.
REQ-032 Interrupt acknowledge (IORQ low and M1 low) SHALL never cause D_OE to be driven.
REQ-033 If RD deasserts during FETCH or LATCH, the FSM SHALL go straight to RELEASE without asserting D_OE.
REQ-034 A new read start SHALL be accepted only in IDLE; strobes seen in RELEASE SHALL be ignored until the next high-to-low edge.
REQ-035 D_OE and MEM_RD SHALL be registered outputs.

Reset
REQ-036 While RST is low, all synchronizer flops SHALL be 1.
REQ-037 While RST is low, FSM=IDLE, D_OE=0, D_OUT=8'h00, MEM_RD=0, MEM_ADDR=0, ERR=0 and the counter SHALL be 0.
REQ-038 Reset asserted in DRIVE SHALL drop D_OE asynchronously in the same instant.
REQ-039 After RST is released, the first read start SHALL require a fresh high-to-low transition of the strobes.

Configuration
REQ-040 Macro ULA_PORT_EN defined: an I/O read start (synchronized IORQ=0, RD=0, M1=1, A[0]=0) SHALL go directly to DRIVE, with D_OUT = {1'b1, EAR, 1'b1, KEYS} captured on entry and the same release and timeout rules applied.
REQ-041 Macro ULA_PORT_EN undefined: all I/O cycles SHALL be ignored, and KEYS and EAR SHALL be unused.

Verification
REQ-042 Write 8'hA5 at memory offset 0; Z80 read of 16'h4000 -> MEM_RD pulse with MEM_ADDR=0, D_OE high 3 cycles after sync, D_OUT=8'hA5, D_OE low one cycle after RD rises.
REQ-043 Reads of 16'h3FFF and 16'h5B00 -> D_OE stays 0 and MEM_RD is never pulsed; a read of 16'h5AFF -> MEM_ADDR=13'h1AFF.
REQ-044 Hold RD low for 100 cycles in range -> D_OE falls after 64 DRIVE cycles and ERR=1; ERR is cleared only by RST.
REQ-045 Assert RST low mid-DRIVE -> D_OE=0 immediately; after release with RD still low, no drive occurs until RD toggles.
REQ-046 With ULA_PORT_EN defined, KEYS=5'b10110, EAR=1, IN from port 16'hFEFE -> D_OUT=8'hF6 with D_OE high; interrupt acknowledge -> D_OE stays 0.
